// File: rtl/op_seq_pkg.sv
// Shared types and constants for the ALU command sequencer and its history FIFO.
package op_seq_pkg;

    localparam int unsigned DW         = 3;
    localparam int unsigned OPW        = 4;
    localparam int unsigned RW         = 8;
    localparam int unsigned OP_COUNT   = 10;
    localparam int unsigned HIST_DEPTH = 8;
    localparam int unsigned TIMEOUT    = 255;
    localparam int unsigned PW         = $clog2(HIST_DEPTH);
    localparam int unsigned CW         = PW + 1;
    localparam int unsigned TW         = $clog2(TIMEOUT + 1);
    localparam int unsigned EW         = 2;

    localparam logic [EW-1:0] ERR_OK      = 2'd0;
    localparam logic [EW-1:0] ERR_ALU     = 2'd1;
    localparam logic [EW-1:0] ERR_TIMEOUT = 2'd2;
    localparam logic [EW-1:0] ERR_ILLEGAL = 2'd3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LATCH = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        PUSH  = 3'd4
    } seq_state_e;

    typedef struct packed {
        logic [OPW-1:0] op;
        logic [DW-1:0]  a;
        logic [DW-1:0]  b;
        logic [RW-1:0]  result;
        logic [EW-1:0]  err;
    } hist_entry_t;

    function automatic logic op_legal(input logic [OPW-1:0] op);
        return (32'(op) < OP_COUNT);
    endfunction

endpackage

// File: rtl/op_command_sequencer_if.sv
// Board-input, ALU handshake and display-drain signals of the command sequencer.
interface op_command_sequencer_if;
    import op_seq_pkg::*;

    logic           go;
    logic [DW-1:0]  a;
    logic [DW-1:0]  b;
    logic [OPW-1:0] op_code_abbreviated;

    logic           alu_start;
    logic [DW-1:0]  alu_a;
    logic [DW-1:0]  alu_b;
    logic [OPW-1:0] alu_op;
    logic           alu_done;
    logic [RW-1:0]  alu_result;
    logic           alu_err;

    logic           disp_valid;
    logic [OPW-1:0] disp_op;
    logic [DW-1:0]  disp_a;
    logic [DW-1:0]  disp_b;
    logic [RW-1:0]  disp_result;
    logic [EW-1:0]  disp_err;
    logic           disp_ready;

    logic           busy;
    logic [CW-1:0]  hist_count;
    logic           hist_drop;

    modport master (
        input  go, a, b, op_code_abbreviated, alu_done, alu_result, alu_err, disp_ready,
        output alu_start, alu_a, alu_b, alu_op, disp_valid, disp_op, disp_a, disp_b,
               disp_result, disp_err, busy, hist_count, hist_drop
    );

    modport slave (
        output go, a, b, op_code_abbreviated, alu_done, alu_result, alu_err, disp_ready,
        input  alu_start, alu_a, alu_b, alu_op, disp_valid, disp_op, disp_a, disp_b,
               disp_result, disp_err, busy, hist_count, hist_drop
    );

endinterface

// File: rtl/op_history_fifo.sv
// Drop-oldest history FIFO with a registered head entry, occupancy and drop pulse.
module op_history_fifo
    import op_seq_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          i_push,
    input  hist_entry_t   i_entry,
    input  logic          i_pop,
    output hist_entry_t   o_head,
    output logic          o_valid,
    output logic [CW-1:0] o_count,
    output logic          o_drop
);

    hist_entry_t   r_mem [HIST_DEPTH];
    hist_entry_t   r_head;
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_valid;
    logic          r_drop;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_rd_adv;
    logic [PW-1:0] w_rd_next;
    logic [CW-1:0] w_count_nxt;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(HIST_DEPTH));
    assign w_pop     = i_pop & ~w_empty;
    // A push into a full FIFO without a pop retires the oldest entry.
    assign w_rd_adv  = w_pop | (i_push & w_full);
    assign w_rd_next = r_rd_ptr + PW'(1);

    always_comb begin
        w_count_nxt = r_count;
        if (i_push && !w_pop && !w_full) begin
            w_count_nxt = r_count + CW'(1);
        end else if (w_pop && !i_push) begin
            w_count_nxt = r_count - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_entry;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_valid  <= 1'b0;
            r_drop   <= 1'b0;
            r_head   <= '0;
        end else begin
            r_count <= w_count_nxt;
            r_valid <= (w_count_nxt != '0);
            r_drop  <= i_push & w_full & ~w_pop;
            if (i_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_rd_adv) begin
                r_rd_ptr <= w_rd_next;
            end
            // New entry becomes head when it lands in an empty (or emptying) FIFO.
            if (i_push && (w_empty || (w_pop && r_count == CW'(1)))) begin
                r_head <= i_entry;
            end else if (w_rd_adv) begin
                r_head <= (r_count == CW'(1) && !i_push) ? hist_entry_t'('0) : r_mem[w_rd_next];
            end
        end
    end

    assign o_head  = r_head;
    assign o_valid = r_valid;
    assign o_count = r_count;
    assign o_drop  = r_drop;

endmodule

// File: rtl/op_command_sequencer.sv
// Turns a debounced-by-sync "go" press into one ALU start/done transaction and logs
// the outcome into the display history FIFO.
module op_command_sequencer
    import op_seq_pkg::*;
(
    input logic                    clk,
    input logic                    reset,
    op_command_sequencer_if.master bus
);

    logic [1:0]     r_sync;
    logic           r_go_q;
    seq_state_e     r_state;
    logic [DW-1:0]  r_a;
    logic [DW-1:0]  r_b;
    logic [OPW-1:0] r_op;
    logic           r_alu_start;
    logic           r_busy;
    logic [TW-1:0]  r_tmo_cnt;
    logic [RW-1:0]  r_result;
    logic [EW-1:0]  r_err;

    seq_state_e     w_state_nxt;
    logic [DW-1:0]  w_a_nxt;
    logic [DW-1:0]  w_b_nxt;
    logic [OPW-1:0] w_op_nxt;
    logic [TW-1:0]  w_tmo_nxt;
    logic [RW-1:0]  w_result_nxt;
    logic [EW-1:0]  w_err_nxt;
    logic           w_go_pulse;
    logic           w_push;
    hist_entry_t    w_entry;
    hist_entry_t    w_head;

    assign w_go_pulse = r_sync[1] & ~r_go_q;

    // Next-state and datapath capture; presses outside IDLE are simply not looked at.
    always_comb begin
        w_state_nxt  = r_state;
        w_a_nxt      = r_a;
        w_b_nxt      = r_b;
        w_op_nxt     = r_op;
        w_tmo_nxt    = r_tmo_cnt;
        w_result_nxt = r_result;
        w_err_nxt    = r_err;
        unique case (r_state)
            IDLE: begin
                if (w_go_pulse) begin
                    w_state_nxt = LATCH;
                end
            end
            LATCH: begin
                w_a_nxt      = bus.a;
                w_b_nxt      = bus.b;
                w_op_nxt     = bus.op_code_abbreviated;
                w_tmo_nxt    = '0;
                w_result_nxt = '0;
                if (op_legal(bus.op_code_abbreviated)) begin
                    w_err_nxt   = ERR_OK;
                    w_state_nxt = ISSUE;
                end else begin
                    w_err_nxt   = ERR_ILLEGAL;
                    w_state_nxt = PUSH;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                // A done arriving on the final counted cycle still wins over the timeout.
                if (bus.alu_done) begin
                    w_result_nxt = bus.alu_result;
                    w_err_nxt    = bus.alu_err ? ERR_ALU : ERR_OK;
                    w_state_nxt  = PUSH;
                end else if (r_tmo_cnt == TW'(TIMEOUT - 1)) begin
                    w_result_nxt = '0;
                    w_err_nxt    = ERR_TIMEOUT;
                    w_state_nxt  = PUSH;
                end else begin
                    w_tmo_nxt = r_tmo_cnt + TW'(1);
                end
            end
            PUSH: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync      <= '0;
            r_go_q      <= 1'b0;
            r_state     <= IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            r_alu_start <= 1'b0;
            r_busy      <= 1'b0;
            r_tmo_cnt   <= '0;
            r_result    <= '0;
            r_err       <= '0;
        end else begin
            r_sync      <= {r_sync[0], bus.go};
            r_go_q      <= r_sync[1];
            r_state     <= w_state_nxt;
            r_a         <= w_a_nxt;
            r_b         <= w_b_nxt;
            r_op        <= w_op_nxt;
            r_alu_start <= (w_state_nxt == ISSUE);
            r_busy      <= (w_state_nxt != IDLE);
            r_tmo_cnt   <= w_tmo_nxt;
            r_result    <= w_result_nxt;
            r_err       <= w_err_nxt;
        end
    end

    assign w_push  = (r_state == PUSH);
    assign w_entry = {r_op, r_a, r_b, r_result, r_err};

    op_history_fifo u_hist (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_entry (w_entry),
        .i_pop   (bus.disp_ready),
        .o_head  (w_head),
        .o_valid (bus.disp_valid),
        .o_count (bus.hist_count),
        .o_drop  (bus.hist_drop)
    );

    assign bus.alu_start   = r_alu_start;
    assign bus.alu_a       = r_a;
    assign bus.alu_b       = r_b;
    assign bus.alu_op      = r_op;
    assign bus.busy        = r_busy;
    assign bus.disp_op     = w_head.op;
    assign bus.disp_a      = w_head.a;
    assign bus.disp_b      = w_head.b;
    assign bus.disp_result = w_head.result;
    assign bus.disp_err    = w_head.err;

endmodule
